// File: rtl/riscv_core_div_iter_if.sv
// Handshake bundle between the divider, its operand producer and its result consumer.
// The master drives operands and accepts results; the slave is the divider itself.
interface riscv_core_div_iter_if #(
    parameter int unsigned XLEN = 64
);
    logic            i_div_valid;
    logic            o_div_ready;
    logic [XLEN-1:0] i_div_dividend;
    logic [XLEN-1:0] i_div_divisor;
    logic            i_div_isword;
    logic            i_div_flush;
    logic            o_div_valid;
    logic            i_div_ready;
    logic [XLEN-1:0] o_div_quotient;
    logic [XLEN-1:0] o_div_remainder;
    logic            o_div_by_zero;

    modport master (
        output i_div_valid,
        output i_div_dividend,
        output i_div_divisor,
        output i_div_isword,
        output i_div_flush,
        output i_div_ready,
        input  o_div_ready,
        input  o_div_valid,
        input  o_div_quotient,
        input  o_div_remainder,
        input  o_div_by_zero
    );

    modport slave (
        input  i_div_valid,
        input  i_div_dividend,
        input  i_div_divisor,
        input  i_div_isword,
        input  i_div_flush,
        input  i_div_ready,
        output o_div_ready,
        output o_div_valid,
        output o_div_quotient,
        output o_div_remainder,
        output o_div_by_zero
    );
endinterface

// File: rtl/riscv_core_div_iter.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Word operations use the lower half of the operands and return zero-extended results.
module riscv_core_div_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    riscv_core_div_iter_if.slave div
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor_q;
    logic            isword_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_r;
    logic            by_zero_q;

    logic [XLEN-1:0] op_dividend;
    logic [XLEN-1:0] op_divisor;
    logic [XLEN-1:0] quo_load;
    logic            divisor_zero;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        op_dividend  = div.i_div_dividend;
        op_divisor   = div.i_div_divisor;
        quo_load     = div.i_div_dividend;
        if (div.i_div_isword) begin
            op_dividend = {{HALF{1'b0}}, div.i_div_dividend[HALF-1:0]};
            op_divisor  = {{HALF{1'b0}}, div.i_div_divisor[HALF-1:0]};
            // Left-align the word dividend so the shared full-width shift path
            // yields the word quotient in the lower half after HALF steps.
            quo_load    = {div.i_div_dividend[HALF-1:0], {HALF{1'b0}}};
        end
        divisor_zero = (op_divisor == '0);
    end

    always_comb begin
        rem_shift = {rem, quo[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        trial_ok  = ~trial[XLEN];
        rem_next  = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {quo[XLEN-2:0], trial_ok};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor_q <= '0;
            isword_q  <= 1'b0;
            result_q  <= '0;
            result_r  <= '0;
            by_zero_q <= 1'b0;
        end else if (div.i_div_flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div.i_div_valid) begin
                        divisor_q <= op_divisor;
                        isword_q  <= div.i_div_isword;
                        rem       <= '0;
                        quo       <= quo_load;
                        if (divisor_zero) begin
                            result_q  <= div.i_div_isword ? {{HALF{1'b0}}, {HALF{1'b1}}} : '1;
                            result_r  <= op_dividend;
                            by_zero_q <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_DONE;
                        end else begin
                            by_zero_q <= 1'b0;
                            cnt       <= div.i_div_isword ? CW'(HALF) : CW'(XLEN);
                            state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_q <= isword_q ? {{HALF{1'b0}}, quo_next[HALF-1:0]} : quo_next;
                        result_r <= isword_q ? {{HALF{1'b0}}, rem_next[HALF-1:0]} : rem_next;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (div.i_div_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign div.o_div_ready     = (state == ST_IDLE);
    assign div.o_div_valid     = (state == ST_DONE);
    assign div.o_div_quotient  = result_q;
    assign div.o_div_remainder = result_r;
    assign div.o_div_by_zero   = by_zero_q;

endmodule

// File: tb/tb_riscv_core_div_iter.sv
// Directed testbench for riscv_core_div_iter: hand-computed results, latency,
// backpressure, flush, asynchronous reset and back-to-back throughput.
module tb_riscv_core_div_iter;

    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    riscv_core_div_iter_if #(.XLEN(XLEN)) bus ();

    riscv_core_div_iter #(.XLEN(XLEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .div   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and returns the edges counted from the accept edge until valid.
    task automatic run_op(input logic [63:0] dvd, input logic [63:0] dvs, input logic word,
                          output int lat, output logic [63:0] q, output logic [63:0] r,
                          output logic bz);
        bus.i_div_dividend = dvd;
        bus.i_div_divisor  = dvs;
        bus.i_div_isword   = word;
        bus.i_div_valid    = 1'b1;
        @(posedge clk); #1;
        bus.i_div_valid = 1'b0;
        lat = 0;
        while (!bus.o_div_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.o_div_valid) begin
            checks++;
            errors++;
            $display("FAIL run_op_timeout: valid=%0b after %0d cycles, need 1", bus.o_div_valid, lat);
        end
        q  = bus.o_div_quotient;
        r  = bus.o_div_remainder;
        bz = bus.o_div_by_zero;
    endtask

    task automatic accept_result();
        bus.i_div_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_div_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.o_div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b need 1", bus.o_div_ready); end
        checks++; if (bus.o_div_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b need 0", bus.o_div_valid); end
        checks++; if (bus.o_div_quotient !== 64'h0) begin errors++; $display("FAIL reset_quotient: got %h need 0", bus.o_div_quotient); end
        checks++; if (bus.o_div_remainder !== 64'h0) begin errors++; $display("FAIL reset_remainder: got %h need 0", bus.o_div_remainder); end
        checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_by_zero: got %0b need 0", bus.o_div_by_zero); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_full_width();
        int lat; logic [63:0] q, r; logic bz;
        run_op(64'd100, 64'd7, 1'b0, lat, q, r, bz);
        checks++; if (lat !== 64) begin errors++; $display("FAIL full_latency: got %0d need 64", lat); end
        checks++; if (q !== 64'd14) begin errors++; $display("FAIL full_quotient: got %h need e", q); end
        checks++; if (r !== 64'd2) begin errors++; $display("FAIL full_remainder: got %h need 2", r); end
        checks++; if (bz !== 1'b0) begin errors++; $display("FAIL full_by_zero: got %0b need 0", bz); end
        accept_result();
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, q, r, bz);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL max_quotient: got %h need ffffffffffffffff", q); end
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL max_remainder: got %h need 0", r); end
        accept_result();
        run_op(64'd5, 64'd9, 1'b0, lat, q, r, bz);
        checks++; if (q !== 64'h0) begin errors++; $display("FAIL small_quotient: got %h need 0", q); end
        checks++; if (r !== 64'd5) begin errors++; $display("FAIL small_remainder: got %h need 5", r); end
        accept_result();
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1'b0, lat, q, r, bz);
        checks++; if (q !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wide_quotient: got %h need ffffffff", q); end
        checks++; if (r !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wide_remainder: got %h need ffffffff", r); end
        accept_result();
    endtask

    task automatic test_word();
        int lat; logic [63:0] q, r; logic bz;
        run_op(64'hDEAD_BEEF_0000_0064, 64'hFFFF_FFFF_0000_0007, 1'b1, lat, q, r, bz);
        checks++; if (lat !== 32) begin errors++; $display("FAIL word_latency: got %0d need 32", lat); end
        checks++; if (q !== 64'hE) begin errors++; $display("FAIL word_quotient: got %h need e", q); end
        checks++; if (r !== 64'h2) begin errors++; $display("FAIL word_remainder: got %h need 2", r); end
        accept_result();
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_0000_0000_0002, 1'b1, lat, q, r, bz);
        checks++; if (q !== 64'h0000_0000_7FFF_FFFF) begin errors++; $display("FAIL word_max_quotient: got %h need 7fffffff", q); end
        checks++; if (r !== 64'h1) begin errors++; $display("FAIL word_max_remainder: got %h need 1", r); end
        accept_result();
    endtask

    task automatic test_div_by_zero();
        int lat; logic [63:0] q, r; logic bz;
        run_op(64'h1234, 64'h0, 1'b0, lat, q, r, bz);
        checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency: got %0d extra cycles need 0", lat); end
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL zero_quotient: got %h need ffffffffffffffff", q); end
        checks++; if (r !== 64'h1234) begin errors++; $display("FAIL zero_remainder: got %h need 1234", r); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL zero_flag: got %0b need 1", bz); end
        accept_result();
        run_op(64'h5555_0000_0000_1234, 64'hABCD_0000_0000_0000, 1'b1, lat, q, r, bz);
        checks++; if (lat !== 0) begin errors++; $display("FAIL wzero_latency: got %0d extra cycles need 0", lat); end
        checks++; if (q !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wzero_quotient: got %h need ffffffff", q); end
        checks++; if (r !== 64'h1234) begin errors++; $display("FAIL wzero_remainder: got %h need 1234", r); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL wzero_flag: got %0b need 1", bz); end
        accept_result();
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] q, r; logic bz;
        run_op(64'd1000, 64'd33, 1'b0, lat, q, r, bz);
        checks++; if (q !== 64'd30 || r !== 64'd10) begin errors++; $display("FAIL bp_result: got q=%h r=%h need 1e/a", q, r); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.o_div_valid !== 1'b1 || bus.o_div_ready !== 1'b0 ||
                bus.o_div_quotient !== 64'd30 || bus.o_div_remainder !== 64'd10) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%0b ready=%0b q=%h r=%h need 1/0/1e/a",
                         i, bus.o_div_valid, bus.o_div_ready, bus.o_div_quotient, bus.o_div_remainder);
            end
        end
        accept_result();
        checks++; if (bus.o_div_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0b need 0", bus.o_div_valid); end
        checks++; if (bus.o_div_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %0b need 1", bus.o_div_ready); end
    endtask

    task automatic test_flush_and_reset();
        int lat; logic [63:0] q, r; logic bz;
        bus.i_div_dividend = 64'd100;
        bus.i_div_divisor  = 64'd7;
        bus.i_div_isword   = 1'b0;
        bus.i_div_valid    = 1'b1;
        @(posedge clk); #1;
        bus.i_div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.i_div_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_div_flush = 1'b0;
        checks++; if (bus.o_div_valid !== 1'b0 || bus.o_div_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle: valid=%0b ready=%0b need 0/1", bus.o_div_valid, bus.o_div_ready); end
        // Flush together with valid in IDLE must reject the operands.
        bus.i_div_divisor = 64'h0;
        bus.i_div_valid   = 1'b1;
        bus.i_div_flush   = 1'b1;
        @(posedge clk); #1;
        bus.i_div_valid = 1'b0;
        bus.i_div_flush = 1'b0;
        checks++; if (bus.o_div_valid !== 1'b0 || bus.o_div_ready !== 1'b1) begin
            errors++; $display("FAIL flush_reject: valid=%0b ready=%0b need 0/1", bus.o_div_valid, bus.o_div_ready); end
        bus.i_div_divisor = 64'd7;
        bus.i_div_valid   = 1'b1;
        @(posedge clk); #1;
        bus.i_div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.o_div_valid !== 1'b0 || bus.o_div_ready !== 1'b1) begin
            errors++; $display("FAIL rst_async: valid=%0b ready=%0b need 0/1", bus.o_div_valid, bus.o_div_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(64'd20, 64'd3, 1'b0, lat, q, r, bz);
        checks++; if (lat !== 64) begin errors++; $display("FAIL post_rst_latency: got %0d need 64", lat); end
        checks++; if (q !== 64'd6 || r !== 64'd2) begin errors++; $display("FAIL post_rst_result: got q=%h r=%h need 6/2", q, r); end
        accept_result();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int accepts[$];
        logic pre;
        bus.i_div_dividend = 64'd100;
        bus.i_div_divisor  = 64'd7;
        bus.i_div_isword   = 1'b1;
        bus.i_div_ready    = 1'b1;
        bus.i_div_valid    = 1'b1;
        cyc = 0;
        while (accepts.size() < 2 && cyc < 200) begin
            pre = bus.o_div_ready;
            @(posedge clk); #1;
            cyc++;
            if (pre) accepts.push_back(cyc);
        end
        bus.i_div_valid = 1'b0;
        checks++;
        if (accepts.size() < 2) begin
            errors++; $display("FAIL b2b_accepts: got %0d accepts need 2", accepts.size());
        end else if (accepts[1] - accepts[0] !== 34) begin
            errors++; $display("FAIL b2b_period: got %0d need 34", accepts[1] - accepts[0]);
        end
        cyc = 0;
        while (!bus.o_div_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (bus.o_div_ready !== 1'b1 || bus.o_div_quotient !== 64'hE) begin
            errors++; $display("FAIL b2b_drain: ready=%0b q=%h need 1/e", bus.o_div_ready, bus.o_div_quotient); end
        bus.i_div_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_div_valid    = 1'b0;
        bus.i_div_dividend = '0;
        bus.i_div_divisor  = '0;
        bus.i_div_isword   = 1'b0;
        bus.i_div_flush    = 1'b0;
        bus.i_div_ready    = 1'b0;
        test_reset();
        test_full_width();
        test_word();
        test_div_by_zero();
        test_backpressure();
        test_flush_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
